// File: rtl/crc8_pkg.sv
// CRC-8 arbiter shared definitions: polynomial, seed, frame width,
// result-slot state type and the single-bit CRC recurrence.
package crc8_pkg;

  localparam int         CRC8_DATA_W = 16;
  localparam logic [7:0] CRC8_POLY   = 8'h2F;
  localparam logic [7:0] CRC8_INIT   = 8'hFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } crc8_state_e;

  // one MSB-first shift of the CRC register
  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       din
  );
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_arb_ctrl_if.sv
// Request/result bundle between requesters, arbiter and result consumer.
// CRC8_CHK_EN adds expected-CRC inputs and the error outputs.
interface crc8_arb_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) ();
  import crc8_pkg::*;

  logic [NUM_REQ-1:0]                  req_vld;
  logic [NUM_REQ-1:0][CRC8_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_rdy;
  logic                                rsp_vld;
  logic                                rsp_rdy;
  logic [ID_W-1:0]                     rsp_id;
  logic [7:0]                          rsp_crc;
  logic                                busy;
`ifdef CRC8_CHK_EN
  logic [NUM_REQ-1:0][7:0]             req_crc_exp;
  logic                                rsp_err;
  logic [7:0]                          err_cnt;
`endif

`ifdef CRC8_CHK_EN
  modport master (
    output req_vld, req_data, req_crc_exp, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_crc, busy,
    input  rsp_err, err_cnt
  );
  modport slave (
    input  req_vld, req_data, req_crc_exp, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_crc, busy,
    output rsp_err, err_cnt
  );
`else
  modport master (
    output req_vld, req_data, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_crc, busy
  );
  modport slave (
    input  req_vld, req_data, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_crc, busy
  );
`endif

endinterface

// File: rtl/crc16to8_parallel.sv
// Combinational CRC-8 over one 16-bit word, MSB first,
// no reflection, no final XOR.
module crc16to8_parallel
  import crc8_pkg::*;
(
  input  logic [CRC8_DATA_W-1:0] data_i,
  input  logic [7:0]             crc_i,
  output logic [7:0]             crc_o
);

  // unrolled bit-serial recurrence
  always_comb begin
    logic [7:0] c;
    c = crc_i;
    for (int i = CRC8_DATA_W - 1; i >= 0; i--) begin
      c = crc8_step(c, data_i[i]);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc8_arb_ctrl.sv
// Round-robin arbiter sharing one CRC-8 core, one-deep result slot.
// Optional CRC8_CHK_EN: expected-CRC compare, error flag, error counter.
module crc8_arb_ctrl
  import crc8_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input logic           clk,
  input logic           rst,
  crc8_arb_ctrl_if.slave bus
);

  crc8_state_e             state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [7:0]              rsp_crc_q, rsp_crc_d;
  logic [ID_W-1:0]         gnt_id;
  logic [NUM_REQ-1:0]      gnt_oh;
  logic                    any_vld;
  logic                    accept;
  logic [CRC8_DATA_W-1:0]  sel_data;
  logic [7:0]              crc_calc;
`ifdef CRC8_CHK_EN
  logic [7:0]              sel_exp;
  logic                    rsp_err_q, rsp_err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
`endif

  function automatic int rr_slot(
    input logic [ID_W-1:0] p,
    input int              off
  );
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // round-robin search starting at ptr, picks payload of the winner
  always_comb begin
    gnt_oh   = '0;
    gnt_id   = '0;
    sel_data = '0;
    any_vld  = 1'b0;
`ifdef CRC8_CHK_EN
    sel_exp  = '0;
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_vld && bus.req_vld[j] &&
            j == rr_slot(ptr_q, off)) begin
          any_vld   = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_id    = ID_W'(j);
          sel_data  = bus.req_data[j];
`ifdef CRC8_CHK_EN
          sel_exp   = bus.req_crc_exp[j];
`endif
        end
      end
    end
  end

  assign accept = !rst && any_vld &&
                  (state_q == ST_EMPTY || bus.rsp_rdy);

  assign bus.req_rdy = accept ? gnt_oh : '0;

  crc16to8_parallel u_crc (
    .data_i (sel_data),
    .crc_i  (CRC8_INIT),
    .crc_o  (crc_calc)
  );

  // slot next-state, pointer advance, result capture
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rsp_id_d  = rsp_id_q;
    rsp_crc_d = rsp_crc_q;
`ifdef CRC8_CHK_EN
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
`endif
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && bus.rsp_rdy) state_d = ST_EMPTY;
    endcase
    if (accept) begin
      if (int'(gnt_id) == NUM_REQ - 1) ptr_d = '0;
      else                             ptr_d = gnt_id + ID_W'(1);
      rsp_id_d  = gnt_id;
      rsp_crc_d = crc_calc;
`ifdef CRC8_CHK_EN
      rsp_err_d = (crc_calc != sel_exp);
`endif
    end
`ifdef CRC8_CHK_EN
    if (state_q == ST_FULL && bus.rsp_rdy && rsp_err_q &&
        err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
`endif
  end

  // state and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      rsp_id_q  <= '0;
      rsp_crc_q <= 8'h00;
`ifdef CRC8_CHK_EN
      rsp_err_q <= 1'b0;
      err_cnt_q <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_crc_q <= rsp_crc_d;
`ifdef CRC8_CHK_EN
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign bus.busy    = (state_q == ST_FULL);
  assign bus.rsp_vld = (state_q == ST_FULL);
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_crc = rsp_crc_q;
`ifdef CRC8_CHK_EN
  assign bus.rsp_err = rsp_err_q;
  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/crc8_arb_ctrl.md
CRC8_ARB_CTRL -- requirements
Module: crc8_arb_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the CRC core (legal range 2..4).
REQ-002 Parameter ID_W, default 2, width of the requester index (ID_W >= clog2(NUM_REQ)).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_vld  input  NUM_REQ  per-requester frame valid.
REQ-006 req_data  input  NUM_REQ x 16  per-requester 16-bit frame payload.
REQ-007 req_rdy  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_crc_exp  input  NUM_REQ x 8  expected CRC per requester; present only with CRC8_CHK_EN.
REQ-009 rsp_vld  output  1  result valid.
REQ-010 rsp_rdy  input  1  result consumer ready.
REQ-011 rsp_id  output  ID_W  index of the requester owning the result.
REQ-012 rsp_crc  output  8  computed CRC-8.
REQ-013 rsp_err  output  1  mismatch flag; present only with CRC8_CHK_EN.
REQ-014 err_cnt  output  8  saturating mismatch counter; present only with CRC8_CHK_EN.
REQ-015 busy  output  1  high while the result slot holds an unconsumed result.

Function
REQ-016 CRC SHALL use poly x^8+x^5+x^3+x^2+x+1, init 0xFF, over one 16-bit word per frame, with no reflection and no final XOR.
REQ-017 One CRC core instance SHALL be shared; exactly one request is accepted per cycle at most.
REQ-018 FSM states SHALL be EMPTY (slot free) and FULL (slot holds result); reset state EMPTY.
REQ-019 Accept condition: any req_vld high AND (state EMPTY OR (FULL AND rsp_rdy)).
REQ-020 Under the accept condition, req_rdy SHALL go high for the granted index only, combinationally in the same cycle.
REQ-021 Arbitration SHALL be round-robin: search starts at ptr; ptr <= grant+1 (mod NUM_REQ) on accept; ptr unchanged otherwise.
REQ-022 Latency SHALL be 1: data accepted at edge N gives registered rsp_vld/rsp_id/rsp_crc valid after edge N.
REQ-023 EMPTY->FULL on accept; FULL->EMPTY on rsp_rdy without accept; FULL->FULL on simultaneous drain and accept (back-to-back, 1 result/cycle).
REQ-024 While FULL and rsp_rdy low, rsp_* outputs SHALL hold stable and req_rdy SHALL be all-zero.
REQ-025 req_vld deasserted without req_rdy SHALL be legal; no state change results.
REQ-026 busy SHALL equal (state == FULL); rsp_vld SHALL equal busy.

Reset
REQ-027 On rst: state EMPTY, ptr 0, rsp_vld 0, rsp_id 0, rsp_crc 0x00, rsp_err 0, err_cnt 0, req_rdy 0.
REQ-028 rst asserted mid-operation SHALL discard any held result immediately; no result is emitted after release until a new accept.

Configuration
REQ-029 Macro CRC8_CHK_EN: when defined, req_crc_exp, rsp_err and err_cnt exist; rsp_err is registered with the result and equals (computed != expected).
REQ-030 With CRC8_CHK_EN, err_cnt SHALL increment by 1 per delivered result (rsp_vld && rsp_rdy) with rsp_err high, and saturate at 0xFF.
REQ-031 Without CRC8_CHK_EN, those ports and registers SHALL be absent; the block is generate-only.

Structure
REQ-032 A shared package crc8_pkg SHALL hold CRC8_POLY (8'h2F), CRC8_INIT (8'hFF), CRC8_DATA_W (16) and the state enum typedef.
REQ-033 The existing crc16to8_parallel core SHALL be instantiated once as the sole sub-module; arbitration stays inline.

Verification
REQ-034 Single request: req_vld[0]=1, data 0x0000 -> req_rdy[0]=1 that cycle; next cycle rsp_vld=1, rsp_id=0, rsp_crc=0xB8.
REQ-035 Contention: both requesters valid continuously, rsp_rdy=1 -> grants alternate 0,1,0,1; one result per cycle; CRC values match the golden model.
REQ-036 Backpressure: rsp_rdy=0 for 5 cycles with a result held -> rsp_* stable, req_rdy=0; rsp_rdy=1 -> drain and accept in the same cycle.
REQ-037 CHK_EN: data 0x0000 with exp 0xB8 -> rsp_err=0; with exp 0xB9 -> rsp_err=1 and err_cnt 0->1; after 300 errors err_cnt=0xFF.
REQ-038 Reset mid-FULL: assert rst while rsp_vld=1 -> rsp_vld=0 with no clock edge; ptr=0; first grant after release goes to requester 0.
